// File: rtl/instruction_queue.sv
// Dual-issue instruction queue between fetch and decode: accepts one fetched pair per cycle,
// presents the two oldest entries. Optional PC tagging is built when IQ_PC_TAG_EN is defined.
module instruction_queue #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned IW    = 32,
  parameter int unsigned PCW   = 12
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           flush,
  input  logic           in_valid,
  input  logic [IW-1:0]  in_instr1,
  input  logic [IW-1:0]  in_instr2,
`ifdef IQ_PC_TAG_EN
  input  logic [PCW-1:0] in_pc,
  output logic [PCW-1:0] out_pc0,
  output logic [PCW-1:0] out_pc1,
`endif
  output logic           enable_pc,
  input  logic [1:0]     pop_count,
  output logic           out_valid0,
  output logic [IW-1:0]  out_instr0,
  output logic           out_valid1,
  output logic [IW-1:0]  out_instr1
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [IW-1:0] mem_q [DEPTH];
  logic [AW-1:0] rd_ptr_q, rd_ptr_d, rd_ptr_nx;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, wr_ptr_nx;
  logic [CW-1:0] count_q, count_d;
  logic          enable_q;
  logic          push;
  logic [1:0]    pop_req, pop_eff;

  always_comb begin
    push      = in_valid & enable_q;
    pop_req   = (pop_count == 2'd3) ? 2'd2 : pop_count;
    // Never pop more than is held; count is at most 1 when this clamps.
    pop_eff   = (CW'(pop_req) > count_q) ? count_q[1:0] : pop_req;
    wr_ptr_nx = wr_ptr_q + AW'(1);
    rd_ptr_nx = rd_ptr_q + AW'(1);
    rd_ptr_d  = rd_ptr_q + AW'(pop_eff);
    wr_ptr_d  = push ? wr_ptr_q + AW'(2) : wr_ptr_q;
    count_d   = count_q + (push ? CW'(2) : CW'(0)) - CW'(pop_eff);
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      enable_q <= 1'b0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      enable_q <= (count_d <= CW'(DEPTH - 2));
    end
  end

  // Storage needs no reset; contents are qualified by count.
  always_ff @(posedge clk) begin
    if (push && !flush) begin
      mem_q[wr_ptr_q]  <= in_instr1;
      mem_q[wr_ptr_nx] <= in_instr2;
    end
  end

  always_comb begin
    enable_pc  = enable_q;
    out_valid0 = (count_q >= CW'(1));
    out_valid1 = (count_q >= CW'(2));
    out_instr0 = out_valid0 ? mem_q[rd_ptr_q]  : '0;
    out_instr1 = out_valid1 ? mem_q[rd_ptr_nx] : '0;
  end

`ifdef IQ_PC_TAG_EN
  logic [PCW-1:0] pc_q [DEPTH];

  always_ff @(posedge clk) begin
    if (push && !flush) begin
      pc_q[wr_ptr_q]  <= in_pc;
      pc_q[wr_ptr_nx] <= in_pc + PCW'(4);
    end
  end

  always_comb begin
    out_pc0 = out_valid0 ? pc_q[rd_ptr_q]  : '0;
    out_pc1 = out_valid1 ? pc_q[rd_ptr_nx] : '0;
  end
`endif

endmodule

// File: tb/tb_instruction_queue.sv
// Self-checking bench for instruction_queue: queue-based reference model compared every cycle,
// plus directed literal checks.
module tb_instruction_queue;
  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] in_instr1 = '0;
  logic [31:0] in_instr2 = '0;
  logic [1:0]  pop_count = '0;
  logic        enable_pc, out_valid0, out_valid1;
  logic [31:0] out_instr0, out_instr1;
`ifdef IQ_PC_TAG_EN
  logic [11:0] in_pc = '0;
  logic [11:0] out_pc0, out_pc1;
  logic [11:0] pq[$];
`endif
  logic [11:0] next_pc = '0;

  int total = 0;
  int bad = 0;
  logic [31:0] mq[$];
  bit m_en = 1'b0;

  instruction_queue #(.DEPTH(DEPTH), .IW(32), .PCW(12)) dut (
    .clk        (clk),
    .reset      (reset),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_instr1  (in_instr1),
    .in_instr2  (in_instr2),
`ifdef IQ_PC_TAG_EN
    .in_pc      (in_pc),
    .out_pc0    (out_pc0),
    .out_pc1    (out_pc1),
`endif
    .enable_pc  (enable_pc),
    .pop_count  (pop_count),
    .out_valid0 (out_valid0),
    .out_instr0 (out_instr0),
    .out_valid1 (out_valid1),
    .out_instr1 (out_instr1)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] mat(int i);
    return (mq.size() > i) ? mq[i] : 32'h0;
  endfunction

  // Reference: FIFO of instructions; fetch allowed while at most DEPTH-2 entries are held.
  task automatic model_edge();
    int pe;
    if (flush) begin
      mq.delete();
`ifdef IQ_PC_TAG_EN
      pq.delete();
`endif
    end else begin
      pe = (pop_count == 2'd3) ? 2 : int'(pop_count);
      if (pe > mq.size()) pe = mq.size();
      for (int k = 0; k < pe; k++) begin
        void'(mq.pop_front());
`ifdef IQ_PC_TAG_EN
        void'(pq.pop_front());
`endif
      end
      if (in_valid && m_en) begin
        mq.push_back(in_instr1);
        mq.push_back(in_instr2);
`ifdef IQ_PC_TAG_EN
        pq.push_back(in_pc);
        pq.push_back(in_pc + 12'd4);
`endif
      end
    end
    m_en = (mq.size() <= DEPTH - 2);
  endtask

  task automatic step(input bit v, input bit fl, input logic [1:0] pc,
                      input logic [31:0] a, input logic [31:0] b);
    in_valid  = v;
    flush     = fl;
    pop_count = pc;
    in_instr1 = a;
    in_instr2 = b;
`ifdef IQ_PC_TAG_EN
    in_pc     = next_pc;
`endif
    next_pc   = next_pc + 12'd8;
    @(posedge clk);
    if (!reset) model_edge();
    @(negedge clk);
  endtask

  always @(negedge clk) begin
    chk("enable_pc", enable_pc, m_en);
    chk("out_valid0", out_valid0, mq.size() >= 1);
    chk("out_valid1", out_valid1, mq.size() >= 2);
    chk("out_instr0", out_instr0, mat(0));
    chk("out_instr1", out_instr1, mat(1));
`ifdef IQ_PC_TAG_EN
    chk("out_pc0", out_pc0, (pq.size() > 0) ? pq[0] : 12'h0);
    chk("out_pc1", out_pc1, (pq.size() > 1) ? pq[1] : 12'h0);
`endif
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_enable", enable_pc, 1'b0);
    chk("rst_valid0", out_valid0, 1'b0);
    chk("rst_instr0", out_instr0, 32'h0);
    reset = 1'b0;
    step(0, 0, 2'd0, 32'h0, 32'h0);
    chk("rel_enable", enable_pc, 1'b1);

    // Single pair then pop both
    step(1, 0, 2'd0, 32'hAAAA_0001, 32'hBBBB_0002);
    chk("pair_i0", out_instr0, 32'hAAAA_0001);
    chk("pair_i1", out_instr1, 32'hBBBB_0002);
    chk("pair_v1", out_valid1, 1'b1);
    step(0, 0, 2'd2, 32'h0, 32'h0);
    chk("popped_v0", out_valid0, 1'b0);
    chk("popped_v1", out_valid1, 1'b0);

    // Fill: pushes accepted while 6 or fewer are held, so the fourth pair lands (8 held)
    for (int i = 0; i < 4; i++) step(1, 0, 2'd0, 32'h1000 + 2 * i, 32'h1001 + 2 * i);
    chk("full_enable", enable_pc, 1'b0);
    chk("full_i0", out_instr0, 32'h1000);
    step(1, 0, 2'd0, 32'hDEAD_0000, 32'hDEAD_0001);
    chk("full_ignored_i0", out_instr0, 32'h1000);

    // Flush while full with push and pop requested
    step(1, 1, 2'd2, 32'hEEEE_0000, 32'hEEEE_0001);
    chk("flush_enable", enable_pc, 1'b1);
    chk("flush_v0", out_valid0, 1'b0);
    step(0, 0, 2'd0, 32'h0, 32'h0);
    chk("flush_idle_v0", out_valid0, 1'b0);

    // Over-pop from count=1
    step(1, 0, 2'd0, 32'h2000, 32'h2001);
    step(0, 0, 2'd1, 32'h0, 32'h0);
    chk("one_left_i0", out_instr0, 32'h2001);
    chk("one_left_v1", out_valid1, 1'b0);
    step(0, 0, 2'd3, 32'h0, 32'h0);
    chk("overpop_v0", out_valid0, 1'b0);
    step(0, 0, 2'd3, 32'h0, 32'h0);
    chk("empty_pop_v0", out_valid0, 1'b0);
    chk("empty_pop_en", enable_pc, 1'b1);

    // Odd pops across pointer wrap
    for (int i = 0; i < 20; i++) begin
      if (i % 2 == 0) step(1, 0, 2'd1, 32'h3000 + i, 32'h3100 + i);
      else step(0, 0, 2'd1, 32'h0, 32'h0);
    end
    chk("wrap_i0", out_instr0, 32'h3112);

    // Asynchronous reset mid-operation
    step(1, 0, 2'd0, 32'h4000, 32'h4001);
    step(1, 0, 2'd0, 32'h4002, 32'h4003);
    #2;
    reset = 1'b1;
    mq.delete();
`ifdef IQ_PC_TAG_EN
    pq.delete();
`endif
    m_en = 1'b0;
    #1;
    chk("midrst_v0", out_valid0, 1'b0);
    chk("midrst_en", enable_pc, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    step(0, 0, 2'd0, 32'h0, 32'h0);
    chk("midrst_rel_en", enable_pc, 1'b1);

`ifdef IQ_PC_TAG_EN
    next_pc = 12'hFFC;
    step(1, 0, 2'd0, 32'h5000, 32'h5001);
    chk("pc_wrap0", out_pc0, 12'hFFC);
    chk("pc_wrap1", out_pc1, 12'h000);
`endif
    step(0, 0, 2'd2, 32'h0, 32'h0);
    chk("final_v0", out_valid0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
